// File: rtl/alu_regfile_sequencer_pkg.sv
// alu_regfile_sequencer_pkg: shared widths, opcode type and sequencer states
package alu_regfile_sequencer_pkg;
   localparam int REGFILE_WIDTH      = 16;
   localparam int REGFILE_ADDR_WIDTH = 4;
   localparam int ALU_OP_WIDTH       = 4;
   typedef logic [ALU_OP_WIDTH-1:0] aluop_t;
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} seq_state_t;
endpackage

// File: rtl/alu_regfile_sequencer_if.sv
// alu_regfile_sequencer_if: command, host-load, register-file and ALU signals around the sequencer
interface alu_regfile_sequencer_if
   import alu_regfile_sequencer_pkg::*;
#(
   parameter int DATA_W = REGFILE_WIDTH,
   parameter int ADDR_W = REGFILE_ADDR_WIDTH,
   parameter int OP_W   = ALU_OP_WIDTH
);
   logic              Cmd_valid, Cmd_ready;
   logic [OP_W-1:0]   Cmd_op;
   logic [ADDR_W-1:0] Cmd_dst, Cmd_src1, Cmd_src2;
   logic              Load_valid, Load_ready;
   logic [ADDR_W-1:0] Load_addr;
   logic [DATA_W-1:0] Load_data;
   logic [ADDR_W-1:0] Read_Addr_1, Read_Addr_2, Write_Addr;
   logic [DATA_W-1:0] Rf_Data_1, Rf_Data_2, Data_In;
   logic              Write_enable;
   logic [DATA_W-1:0] Alu_A, Alu_B, Alu_result;
   logic [OP_W-1:0]   Alu_op;
   logic              Alu_start, Alu_done, Done, Err;
   modport slave (
      input  Cmd_valid, Cmd_op, Cmd_dst, Cmd_src1, Cmd_src2,
      input  Load_valid, Load_addr, Load_data,
      input  Rf_Data_1, Rf_Data_2, Alu_done, Alu_result,
      output Cmd_ready, Load_ready, Read_Addr_1, Read_Addr_2, Write_Addr, Data_In, Write_enable,
      output Alu_A, Alu_B, Alu_op, Alu_start, Done, Err
   );
   modport master (
      output Cmd_valid, Cmd_op, Cmd_dst, Cmd_src1, Cmd_src2,
      output Load_valid, Load_addr, Load_data,
      output Rf_Data_1, Rf_Data_2, Alu_done, Alu_result,
      input  Cmd_ready, Load_ready, Read_Addr_1, Read_Addr_2, Write_Addr, Data_In, Write_enable,
      input  Alu_A, Alu_B, Alu_op, Alu_start, Done, Err
   );
endinterface

// File: rtl/alu_wdog_timer.sv
// alu_wdog_timer: counts EXEC cycles since Alu_start and flags the last allowed one
module alu_wdog_timer #(
   parameter int LIMIT = 16
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic exp_o
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt_q, cnt_d;
   // the launch cycle itself counts as the first EXEC cycle, so a clear loads 1
   always_comb cnt_d = clr_i ? W'(1) : en_i ? cnt_q + W'(1) : cnt_q;
   // cycle counter register
   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign exp_o = en_i && !clr_i && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/alu_regfile_sequencer.sv
// alu_regfile_sequencer: runs dst <= src1 OP src2 through the register file and a multi-cycle ALU, sharing the write port with host loads
module alu_regfile_sequencer
   import alu_regfile_sequencer_pkg::*;
#(
   parameter int DATA_W         = REGFILE_WIDTH,
   parameter int ADDR_W         = REGFILE_ADDR_WIDTH,
   parameter int OP_W           = ALU_OP_WIDTH,
   parameter int TIMEOUT_CYCLES = 16,
   parameter bit ZERO_REG_WP    = 1'b0
) (
   input logic Clock,
   input logic Reset_n,
   alu_regfile_sequencer_if.slave bus
);
   seq_state_t        state_q;
   logic [OP_W-1:0]   op_q, alu_op_q;
   logic [ADDR_W-1:0] dst_q, ra1_q, ra2_q, wa_d;
   logic [DATA_W-1:0] a_q, b_q, res_q;
   logic              start_q, done_q, wb_d, hit_d, tmo, wr_d;
   alu_wdog_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .clr_i   (start_q),
      .en_i    (state_q == EXEC),
      .exp_o   (tmo)
   );
   // writeback owns the write port; otherwise an accepted host load drives it
   always_comb begin
      wb_d  = state_q == WB;
      hit_d = state_q == EXEC && !start_q && bus.Alu_done;
      wa_d  = wb_d ? dst_q : bus.Load_addr;
      wr_d  = wb_d || (bus.Load_valid && bus.Load_ready);
   end
   // instruction sequencer: IDLE -> READ -> EXEC -> WB -> IDLE, timeout drops back to IDLE
   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         alu_op_q <= '0;
         dst_q    <= '0;
         ra1_q    <= '0;
         ra2_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (bus.Cmd_valid) begin
               op_q    <= bus.Cmd_op;
               dst_q   <= bus.Cmd_dst;
               ra1_q   <= bus.Cmd_src1;
               ra2_q   <= bus.Cmd_src2;
               state_q <= READ;
            end
            READ: begin
               a_q      <= bus.Rf_Data_1;
               b_q      <= bus.Rf_Data_2;
               alu_op_q <= op_q;
               start_q  <= 1'b1;
               state_q  <= EXEC;
            end
            EXEC: if (hit_d) begin
               res_q   <= bus.Alu_result;
               done_q  <= 1'b1;
               state_q <= WB;
            end else if (tmo) state_q <= IDLE;
            WB: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   assign bus.Cmd_ready    = Reset_n && state_q == IDLE;
   assign bus.Load_ready   = Reset_n && !wb_d;
   assign bus.Read_Addr_1  = ra1_q;
   assign bus.Read_Addr_2  = ra2_q;
   assign bus.Write_Addr   = wa_d;
   assign bus.Data_In      = wb_d ? res_q : bus.Load_data;
   assign bus.Write_enable = wr_d && !(ZERO_REG_WP && wa_d == '0);
   assign bus.Alu_A        = a_q;
   assign bus.Alu_B        = b_q;
   assign bus.Alu_op       = alu_op_q;
   assign bus.Alu_start    = start_q;
   assign bus.Done         = done_q;
   assign bus.Err          = state_q == EXEC && tmo && !hit_d;
endmodule

// File: tb/tb_alu_regfile_sequencer.sv
// tb_alu_regfile_sequencer: directed vectors and corner sequences for the ALU/register-file sequencer
module tb_alu_regfile_sequencer;
   import alu_regfile_sequencer_pkg::*;
   localparam aluop_t OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;
   typedef struct {
      aluop_t      op;
      logic [3:0]  dst, s1, s2;
      logic [15:0] a, b, res;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b1, alu_en;
   logic [15:0] rf [16];
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   alu_regfile_sequencer_if #(.DATA_W(16), .ADDR_W(4), .OP_W(4)) bus ();
   alu_regfile_sequencer_if #(.DATA_W(16), .ADDR_W(4), .OP_W(4)) zbus ();
   alu_regfile_sequencer #(.TIMEOUT_CYCLES(16), .ZERO_REG_WP(1'b0)) dut (
      .Clock(clk), .Reset_n(rst_n), .bus(bus.slave));
   alu_regfile_sequencer #(.TIMEOUT_CYCLES(16), .ZERO_REG_WP(1'b1)) dut_z (
      .Clock(clk), .Reset_n(rst_n), .bus(zbus.slave));
   function automatic logic [15:0] alu_f(input aluop_t op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return 16'h0;
      endcase
   endfunction
   always @(posedge clk) if (bus.Write_enable) rf[bus.Write_Addr] <= bus.Data_In;
   assign bus.Rf_Data_1 = rf[bus.Read_Addr_1];
   assign bus.Rf_Data_2 = rf[bus.Read_Addr_2];
   assign zbus.Rf_Data_1 = 16'h0;
   assign zbus.Rf_Data_2 = 16'h0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.Alu_done <= 1'b0;
         bus.Alu_result <= 16'h0;
         zbus.Alu_done <= 1'b0;
         zbus.Alu_result <= 16'h0;
      end else begin
         bus.Alu_done <= bus.Alu_start && alu_en;
         bus.Alu_result <= alu_f(bus.Alu_op, bus.Alu_A, bus.Alu_B);
         zbus.Alu_done <= zbus.Alu_start;
         zbus.Alu_result <= 16'h0042;
      end
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic load(input logic [3:0] a, input logic [15:0] d);
      bus.Load_valid = 1'b1;
      bus.Load_addr = a;
      bus.Load_data = d;
      #1;
      check("load_ready", 32'(bus.Load_ready), 32'd1);
      @(negedge clk);
      bus.Load_valid = 1'b0;
   endtask
   task automatic send_cmd(input aluop_t op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
      check("cmd_ready_idle", 32'(bus.Cmd_ready), 32'd1);
      bus.Cmd_valid = 1'b1;
      bus.Cmd_op = op;
      bus.Cmd_dst = d;
      bus.Cmd_src1 = s1;
      bus.Cmd_src2 = s2;
      @(negedge clk);
      bus.Cmd_valid = 1'b0;
      check("read_addr_1", 32'(bus.Read_Addr_1), 32'(s1));
      check("read_addr_2", 32'(bus.Read_Addr_2), 32'(s2));
   endtask
   task automatic run_vec(input vec_t t, input string nm);
      int busy = 0;
      send_cmd(t.op, t.dst, t.s1, t.s2);
      if (!bus.Cmd_ready) busy++;
      @(negedge clk);
      if (!bus.Cmd_ready) busy++;
      check({nm, "/alu_start"}, 32'(bus.Alu_start), 32'd1);
      check({nm, "/alu_a"}, 32'(bus.Alu_A), 32'(t.a));
      check({nm, "/alu_b"}, 32'(bus.Alu_B), 32'(t.b));
      check({nm, "/alu_op"}, 32'(bus.Alu_op), 32'(t.op));
      @(negedge clk);
      if (!bus.Cmd_ready) busy++;
      check({nm, "/t3_quiet"}, {30'd0, bus.Done, bus.Write_enable}, 32'd0);
      @(negedge clk);
      if (!bus.Cmd_ready) busy++;
      check({nm, "/wb_we"}, 32'(bus.Write_enable), 32'd1);
      check({nm, "/wb_addr"}, 32'(bus.Write_Addr), 32'(t.dst));
      check({nm, "/wb_data"}, 32'(bus.Data_In), 32'(t.res));
      check({nm, "/done"}, 32'(bus.Done), 32'd1);
      @(negedge clk);
      check({nm, "/ready_t5"}, 32'(bus.Cmd_ready), 32'd1);
      check({nm, "/busy_cycles"}, 32'(busy), 32'd4);
      check({nm, "/done_off"}, 32'(bus.Done), 32'd0);
   endtask
   vec_t v [6];
   vec_t dep;
   int we_seen, done_seen;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
   initial begin
      v[0] = '{OP_ADD, 4'd3, 4'd1, 4'd2, 16'h0005, 16'h0003, 16'h0008};
      v[1] = '{OP_SUB, 4'd5, 4'd6, 4'd7, 16'h0010, 16'h0003, 16'h000D};
      v[2] = '{OP_AND, 4'd8, 4'd9, 4'd10, 16'hF0F0, 16'h3C3C, 16'h3030};
      v[3] = '{OP_OR, 4'd11, 4'd12, 4'd13, 16'h1200, 16'h0034, 16'h1234};
      v[4] = '{OP_XOR, 4'd6, 4'd6, 4'd7, 16'hFFFF, 16'h00FF, 16'hFF00};
      v[5] = '{OP_SUB, 4'd9, 4'd12, 4'd13, 16'h0003, 16'h0005, 16'hFFFE};
      dep  = '{OP_ADD, 4'd3, 4'd3, 4'd1, 16'h0008, 16'h0005, 16'h000D};
      alu_en = 1'b1;
      bus.Cmd_valid = 1'b0; bus.Cmd_op = '0; bus.Cmd_dst = '0; bus.Cmd_src1 = '0; bus.Cmd_src2 = '0;
      bus.Load_valid = 1'b1; bus.Load_addr = 4'd9; bus.Load_data = 16'hDEAD;
      zbus.Cmd_valid = 1'b0; zbus.Cmd_op = '0; zbus.Cmd_dst = '0; zbus.Cmd_src1 = '0; zbus.Cmd_src2 = '0;
      zbus.Load_valid = 1'b0; zbus.Load_addr = '0; zbus.Load_data = '0;
      #1 rst_n = 1'b0;
      #1;
      check("rst/cmd_ready", 32'(bus.Cmd_ready), 32'd0);
      check("rst/load_ready", 32'(bus.Load_ready), 32'd0);
      check("rst/write_enable", 32'(bus.Write_enable), 32'd0);
      check("rst/outputs", {28'd0, bus.Alu_start, bus.Done, bus.Err, 1'b0}, 32'd0);
      check("rst/alu_a", 32'(bus.Alu_A), 32'd0);
      bus.Load_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst/cmd_ready", 32'(bus.Cmd_ready), 32'd1);
      check("post_rst/load_ready", 32'(bus.Load_ready), 32'd1);
      @(negedge clk);
      zbus.Cmd_valid = 1'b1; zbus.Cmd_op = OP_ADD; zbus.Cmd_dst = 4'd0; zbus.Cmd_src1 = 4'd1; zbus.Cmd_src2 = 4'd2;
      @(negedge clk);
      zbus.Cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("zero/done", 32'(zbus.Done), 32'd1);
      check("zero/wb_we", 32'(zbus.Write_enable), 32'd0);
      check("zero/wb_addr", 32'(zbus.Write_Addr), 32'd0);
      @(negedge clk);
      check("zero/cmd_ready", 32'(zbus.Cmd_ready), 32'd1);
      zbus.Load_valid = 1'b1; zbus.Load_addr = 4'd0; zbus.Load_data = 16'h0055;
      #1;
      check("zero/load_ready", 32'(zbus.Load_ready), 32'd1);
      check("zero/load_we", 32'(zbus.Write_enable), 32'd0);
      @(negedge clk);
      zbus.Load_addr = 4'd5;
      #1;
      check("zero/load5_we", 32'(zbus.Write_enable), 32'd1);
      @(negedge clk);
      zbus.Load_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load(v[i].s1, v[i].a);
         load(v[i].s2, v[i].b);
         run_vec(v[i], $sformatf("vec%0d", i));
      end
      load(4'd1, 16'h0005);
      load(4'd2, 16'h0003);
      send_cmd(OP_ADD, 4'd3, 4'd1, 4'd2);
      repeat (3) @(negedge clk);
      bus.Load_valid = 1'b1; bus.Load_addr = 4'd4; bus.Load_data = 16'h00AA;
      #1;
      check("arb/load_ready_wb", 32'(bus.Load_ready), 32'd0);
      check("arb/wb_addr", 32'(bus.Write_Addr), 32'd3);
      check("arb/wb_data", 32'(bus.Data_In), 32'h8);
      @(negedge clk);
      check("arb/load_ready_next", 32'(bus.Load_ready), 32'd1);
      check("arb/load_addr", 32'(bus.Write_Addr), 32'd4);
      check("arb/load_data", 32'(bus.Data_In), 32'hAA);
      check("arb/load_we", 32'(bus.Write_enable), 32'd1);
      @(negedge clk);
      bus.Load_valid = 1'b0;
      check("arb/r4", 32'(rf[4]), 32'hAA);
      check("arb/r3", 32'(rf[3]), 32'h8);
      send_cmd(OP_ADD, 4'd5, 4'd1, 4'd2);
      bus.Load_valid = 1'b1; bus.Load_addr = 4'd1; bus.Load_data = 16'h0064;
      #1;
      check("hazard/load_ready", 32'(bus.Load_ready), 32'd1);
      @(negedge clk);
      bus.Load_valid = 1'b0;
      check("hazard/alu_a_old", 32'(bus.Alu_A), 32'h5);
      check("hazard/r1_new", 32'(rf[1]), 32'h64);
      repeat (2) @(negedge clk);
      check("hazard/wb_data", 32'(bus.Data_In), 32'h8);
      @(negedge clk);
      load(4'd1, 16'h0005);
      alu_en = 1'b0;
      we_seen = 0;
      send_cmd(OP_ADD, 4'd7, 4'd1, 4'd2);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (bus.Write_enable) we_seen++;
         if (k == 15) check("tmo/err_k15", 32'(bus.Err), 32'd0);
         if (k == 16) check("tmo/err_k16", 32'(bus.Err), 32'd1);
      end
      @(negedge clk);
      check("tmo/cmd_ready", 32'(bus.Cmd_ready), 32'd1);
      check("tmo/err_off", 32'(bus.Err), 32'd0);
      check("tmo/no_write", 32'(we_seen), 32'd0);
      alu_en = 1'b1;
      send_cmd(OP_ADD, 4'd3, 4'd1, 4'd2);
      @(negedge clk);
      check("rstx/alu_start", 32'(bus.Alu_start), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstx/alu_start_off", 32'(bus.Alu_start), 32'd0);
      check("rstx/we_done", {30'd0, bus.Write_enable, bus.Done}, 32'd0);
      check("rstx/cmd_ready", 32'(bus.Cmd_ready), 32'd0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.Done) done_seen++;
      end
      rst_n = 1'b1;
      #1;
      check("rstx/ready_after", 32'(bus.Cmd_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         if (bus.Done) done_seen++;
      end
      check("rstx/no_done", 32'(done_seen), 32'd0);
      run_vec(v[0], "rerun");
      run_vec(dep, "dep");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
